subbytes_stream: RTL and testbench

Parametrised, fully pipelined AES SubBytes stage operating on LANES bytes per beat, with per-beat forward/inverse mode and a valid/ready handshake on both sides. Each accepted beat is substituted lane-wise through the S-box, registered once, then queued in an output FIFO so downstream stalls never drop data. The block sits between the pixel/state source and ShiftRows, and streams continuously without buffering a whole image.

---
 rtl/aes_pkg.sv | 49 ++++
 rtl/aes_sbox.sv | 17 +
 rtl/subbytes_stream.sv | 121 ++++++++++++
 tb/tb_subbytes_stream.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants: byte width and the forward/inverse S-box tables.
// Latency: n/a (constants only).
// Backpressure: n/a.
package aes_pkg;

   localparam int BYTE_W = 8;

   localparam logic [7:0] SBOX_FWD [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] SBOX_INV [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   // One byte lane; beats are built from LANES of these plus the frame marker.
   typedef logic [BYTE_W-1:0] lane_t;

endpackage

// File: rtl/aes_sbox.sv
// Single-byte AES S-box lookup, forward or inverse selected per call.
// Latency: purely combinational.
// Backpressure: none.
// Ports: din - byte in; inv - 0 forward / 1 inverse; dout - substituted byte.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [BYTE_W-1:0] din,
   input  logic              inv,
   output logic [BYTE_W-1:0] dout
);

   always_comb begin
      dout = inv ? SBOX_INV[din] : SBOX_FWD[din];
   end

endmodule

// File: rtl/subbytes_stream.sv
// Streaming AES SubBytes over LANES bytes/beat with per-beat fwd/inv select.
// Latency: 2 edges from input transfer to out_valid (S1 register, then FIFO push).
// Backpressure: credit-based in_ready from registers only; FIFO never overflows.
// Ports: in_valid/in_ready/in_data/in_inv/in_last - input beat; out_valid/out_ready/
//        out_data/out_last - FWFT output; beat_count - accepted beats, wraps.
module subbytes_stream
   import aes_pkg::*;
#(
   parameter int LANES      = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [BYTE_W*LANES-1:0] in_data,
   input  logic                    in_inv,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [BYTE_W*LANES-1:0] out_data,
   output logic                    out_last,
   output logic [CNT_W-1:0]        beat_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   // One spare bit so count + s1_valid can never overflow the compare.
   localparam int OCC_W = PTR_W + 2;

   typedef struct packed {
      logic [BYTE_W*LANES-1:0] data;
      logic                    last;
   } beat_t;

   logic [BYTE_W*LANES-1:0] sub_data;

   genvar gi;
   for (gi = 0; gi < LANES; gi++) begin : g_lane
      aes_sbox u_sbox (
         .din  (in_data[BYTE_W*gi +: BYTE_W]),
         .inv  (in_inv),
         .dout (sub_data[BYTE_W*gi +: BYTE_W])
      );
   end

   beat_t             s1_q, s1_d;
   logic              s1_valid_q, s1_valid_d;
   beat_t             mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    count_q, count_d;
   logic [CNT_W-1:0]  beat_count_q, beat_count_d;

   logic              in_fire;
   logic              push;
   logic              pop;
   logic [OCC_W-1:0]  occupancy;
   beat_t             head;

   always_comb begin
      // A beat sitting in S1 already owns a FIFO slot, so it counts as used.
      occupancy  = OCC_W'(count_q) + OCC_W'(s1_valid_q);
      in_ready   = occupancy < OCC_W'(FIFO_DEPTH);
      in_fire    = in_valid && in_ready;

      out_valid  = (count_q != '0);
      pop        = out_valid && out_ready;
      push       = s1_valid_q;

      head       = mem_q[rd_ptr_q];
      out_data   = out_valid ? head.data : '0;
      out_last   = out_valid ? head.last : 1'b0;
      beat_count = beat_count_q;

      s1_valid_d = in_fire;
      s1_d       = s1_q;
      if (in_fire) begin
         s1_d.data = sub_data;
         s1_d.last = in_last;
      end

      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      beat_count_d = beat_count_q + CNT_W'(in_fire);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q         <= '0;
         s1_valid_q   <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         beat_count_q <= '0;
      end else begin
         s1_q         <= s1_d;
         s1_valid_q   <= s1_valid_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         beat_count_q <= beat_count_d;
      end
   end

   // Storage needs no reset: contents are only visible while count_q != 0.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= s1_q;
      end
   end

endmodule

// File: tb/tb_subbytes_stream.sv
module tb_subbytes_stream;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, in_inv, in_last;
   logic [127:0] in_data;
   logic         out_valid, out_ready, out_last;
   logic [127:0] out_data;
   logic [31:0]  beat_count;

   logic         b_in_valid, b_in_ready, b_in_inv, b_in_last;
   logic [7:0]   b_in_data;
   logic         b_out_valid, b_out_ready, b_out_last;
   logic [7:0]   b_out_data;
   logic [3:0]   b_beat_count;

   always #5 clk = ~clk;

   subbytes_stream #(.LANES(16), .FIFO_DEPTH(4), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_inv(in_inv), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .beat_count(beat_count));

   subbytes_stream #(.LANES(1), .FIFO_DEPTH(4), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .in_inv(b_in_inv), .in_last(b_in_last), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_data(b_out_data), .out_last(b_out_last), .beat_count(b_beat_count));

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference S-box derived from GF(2^8) arithmetic, independent of the RTL tables.
   logic [7:0] fwd_tab [256];
   logic [7:0] inv_tab [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic       hi;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = a << 1;
         if (hi) a = a ^ 8'h1b;
         b  = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic build_tables();
      logic [7:0] x, y, iv, s;
      for (int i = 0; i < 256; i++) begin
         x  = 8'(i);
         iv = 8'h00;
         if (x != 0) begin
            for (int j = 1; j < 256; j++) begin
               y = 8'(j);
               if (gmul(x, y) == 8'h01) iv = y;
            end
         end
         s = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
         fwd_tab[i] = s;
         inv_tab[s] = x;
      end
   endtask

   function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
      logic [127:0] r;
      for (int i = 0; i < 16; i++)
         r[8*i +: 8] = inv ? inv_tab[d[8*i +: 8]] : fwd_tab[d[8*i +: 8]];
      return r;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Scoreboard: push on input handshake, pop on output handshake (sampled mid-cycle).
   typedef struct packed { logic [127:0] d; logic l; } exp_t;
   exp_t         sbq [$];
   exp_t         mon_e;
   logic         hold_vld = 1'b0;
   logic [127:0] hold_d;
   logic         hold_l;
   int           accepted = 0;

   always @(negedge clk) begin
      if (rst) begin
         sbq.delete();
         hold_vld = 1'b0;
         accepted = 0;
      end else begin
         if (out_valid) begin
            if (hold_vld) begin
               chk("hold_data", out_data, hold_d);
               chk("hold_last", {127'd0, out_last}, {127'd0, hold_l});
            end
            if (out_ready) begin
               if (sbq.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL sb_spurious: got beat %0h, expected none", out_data);
               end else begin
                  mon_e = sbq.pop_front();
                  chk("sb_data", out_data, mon_e.d);
                  chk("sb_last", {127'd0, out_last}, {127'd0, mon_e.l});
               end
            end
         end else begin
            chk("idle_zero", {out_data, out_last}, '0);
         end
         hold_vld = out_valid && !out_ready;
         hold_d   = out_data;
         hold_l   = out_last;
         if (in_valid && in_ready) begin
            sbq.push_back('{d: model(in_data, in_inv), l: in_last});
            accepted++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [127:0] d, input logic inv, input logic last);
      int w = 0;
      in_data  = d;
      in_inv   = inv;
      in_last  = last;
      in_valid = 1'b1;
      while (!in_ready && w < 50) begin
         step();
         w++;
      end
      chk("send_ready", {127'd0, in_ready}, 128'd1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int w = 0;
      out_ready = 1'b1;
      while (sbq.size() != 0 && w < 200) begin
         step();
         w++;
      end
      chk(name, 128'(sbq.size()), 128'd0);
   endtask

   typedef struct {
      logic [127:0] din;
      logic         inv;
      logic         last;
      logic [127:0] exp_d;
      logic         exp_l;
   } vec_t;

   vec_t vt [6];
   int   acc, sent, cyc;
   logic took, b_t;

   initial begin
      vt[0] = '{128'h0, 1'b0, 1'b0, {16{8'h63}}, 1'b0};
      vt[1] = '{128'h53, 1'b0, 1'b0, {{15{8'h63}}, 8'hed}, 1'b0};
      vt[2] = '{128'hed, 1'b1, 1'b0, {{15{8'h52}}, 8'h53}, 1'b0};
      vt[3] = '{128'h01, 1'b0, 1'b1, {{15{8'h63}}, 8'h7c}, 1'b1};
      vt[4] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b0, 1'b0,
                128'h637c777bf26b6fc53001672bfed7ab76, 1'b0};
      vt[5] = '{128'h637c777bf26b6fc53001672bfed7ab76, 1'b1, 1'b1,
                128'h000102030405060708090a0b0c0d0e0f, 1'b1};

      build_tables();
      rst = 1'b1;
      in_valid = 1'b0; in_data = '0; in_inv = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      b_in_valid = 1'b0; b_in_data = '0; b_in_inv = 1'b0; b_in_last = 1'b0; b_out_ready = 1'b0;
      repeat (3) step();

      chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
      chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
      chk("rst_out_data", out_data, 128'd0);
      chk("rst_out_last", {127'd0, out_last}, 128'd0);
      chk("rst_beat_count", 128'(beat_count), 128'd0);
      chk("rst_b_in_ready", {127'd0, b_in_ready}, 128'd1);
      chk("rst_b_beat_count", 128'(b_beat_count), 128'd0);
      rst = 1'b0;
      step();

      // Single beats with an empty FIFO: one-cycle latency gap, one-cycle output pulse.
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         send(vt[i].din, vt[i].inv, vt[i].last);
         chk("lat_not_yet", {127'd0, out_valid}, 128'd0);
         chk("tbl_beat_count", 128'(beat_count), 128'(i + 1));
         step();
         chk("tbl_valid", {127'd0, out_valid}, 128'd1);
         chk("tbl_data", out_data, vt[i].exp_d);
         chk("tbl_last", {127'd0, out_last}, {127'd0, vt[i].exp_l});
         step();
         chk("tbl_one_cycle", {127'd0, out_valid}, 128'd0);
      end

      // Interleaved fwd/inv beats queued behind a stall, then released in order.
      out_ready = 1'b0;
      for (int i = 1; i <= 3; i++) send(vt[i].din, vt[i].inv, vt[i].last);
      out_ready = 1'b1;
      for (int j = 0; j < 3; j++) begin
         int w = 0;
         while (!out_valid && w < 10) begin
            step();
            w++;
         end
         chk("ilv_lane0", 128'(out_data[7:0]), 128'(vt[j + 1].exp_d[7:0]));
         chk("ilv_last", {127'd0, out_last}, {127'd0, vt[j + 1].exp_l});
         step();
      end
      drain("ilv_drain");

      // Credit backpressure: exactly FIFO_DEPTH beats accepted while stalled.
      out_ready = 1'b0;
      acc = 0;
      in_data = rnd128(); in_inv = 1'b0; in_last = 1'b0; in_valid = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (!in_ready) break;
         step();
         acc++;
         in_data = rnd128(); in_inv = 1'($urandom_range(1)); in_last = 1'($urandom_range(1));
      end
      chk("bp_accepted", 128'(acc), 128'd4);
      step(); step();
      chk("bp_still_blocked", {127'd0, in_ready}, 128'd0);
      out_ready = 1'b1;
      chk("bp_ready_before_pop", {127'd0, in_ready}, 128'd0);
      step();
      chk("bp_ready_after_pop", {127'd0, in_ready}, 128'd1);
      step();
      in_valid = 1'b0;
      drain("bp_drain");

      // Random handshakes on both sides against the scoreboard.
      took = 1'b1; sent = 0; cyc = 0;
      while (sent < 10000 && cyc < 40000) begin
         if (!in_valid || took) begin
            in_valid = ($urandom_range(3) != 0);
            in_data  = rnd128();
            in_inv   = 1'($urandom_range(1));
            in_last  = 1'($urandom_range(1));
         end
         out_ready = ($urandom_range(3) != 0);
         took = in_valid && in_ready;
         step();
         cyc++;
         if (took) sent++;
      end
      in_valid = 1'b0;
      chk("rand_sent", 128'(sent), 128'd10000);
      drain("rand_drain");
      chk("rand_beat_count", 128'(beat_count), 128'(accepted));

      // Reset with three beats queued and S1 occupied.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(rnd128(), 1'($urandom_range(1)), 1'b1);
      chk("pre_rst_valid", {127'd0, out_valid}, 128'd1);
      chk("pre_rst_full", {127'd0, in_ready}, 128'd0);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", {127'd0, out_valid}, 128'd0);
      chk("mid_rst_data", out_data, 128'd0);
      chk("mid_rst_last", {127'd0, out_last}, 128'd0);
      chk("mid_rst_in_ready", {127'd0, in_ready}, 128'd1);
      chk("mid_rst_count", 128'(beat_count), 128'd0);
      step(); step();
      rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("post_rst_no_stale", {127'd0, out_valid}, 128'd0);
      end
      chk("post_rst_count", 128'(beat_count), 128'd0);

      // Single-lane instance: forward 0x00, then 16 more beats to wrap a 4-bit counter.
      b_out_ready = 1'b1;
      b_in_data = 8'h00; b_in_inv = 1'b0; b_in_last = 1'b1; b_in_valid = 1'b1;
      chk("b_ready", {127'd0, b_in_ready}, 128'd1);
      step();
      b_in_valid = 1'b0;
      chk("b_lat_not_yet", {127'd0, b_out_valid}, 128'd0);
      step();
      chk("b_valid", {127'd0, b_out_valid}, 128'd1);
      chk("b_data", 128'(b_out_data), 128'h63);
      chk("b_last", {127'd0, b_out_last}, 128'd1);
      chk("b_count1", 128'(b_beat_count), 128'd1);
      b_in_valid = 1'b1; b_in_last = 1'b0;
      sent = 0; cyc = 0;
      while (sent < 16 && cyc < 100) begin
         b_t = b_in_ready;
         step();
         cyc++;
         if (b_t) begin
            sent++;
            b_in_data = 8'(sent);
         end
      end
      b_in_valid = 1'b0;
      chk("b_sent", 128'(sent), 128'd16);
      chk("b_count_wrap", 128'(b_beat_count), 128'd1);
      repeat (4) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
